fir_axil_ctrl: RTL and testbench
================================

// Module: fir_axil_ctrl
// PURPOSE
//   AXI-Lite slave register block that sits downstream of the Wishbone-to-AXI bridge, in front of the FIR datapath.
//   Holds the ap_ctrl handshake and data_length, and gives access to the tap-coefficient SRAM.
//   Issues the engine start pulse and records engine completion.
//   No B channel: a write completes when awready and wready are high together in one cycle.
// PARAMETERS
//   ADDR_WIDTH  12      AXI-Lite address width (byte address)
//   DATA_WIDTH  32      register / tap word width
//   TAP_NUM     11      number of tap words behind TAP_BASE
//   TAP_BASE    12'h080 byte offset of tap word 0
// PORTS
//   axis_clk       in   1   sole clock
//   axis_rst_n     in   1   asynchronous reset, active low
//   awvalid        in   1   write address valid; always arrives together with wvalid
//   awready        out  1   write address accept
//   awaddr         in   12  write byte address
//   wvalid         in   1   write data valid
//   wready         out  1   write data accept; always asserted in the same cycle as awready
//   wdata          in   32  write data
//   arvalid        in   1   read address valid
//   arready        out  1   read address accept
//   araddr         in   12  read byte address
//   rvalid         out  1   read data valid
//   rready         in   1   read data accept
//   rdata          out  32  read data
//   tap_EN         out  1   tap SRAM enable
//   tap_WE         out  4   tap SRAM byte write enables
//   tap_A          out  12  tap SRAM byte address = addr - TAP_BASE
//   tap_Di         out  32  tap SRAM write data
//   tap_Do         in   32  tap SRAM read data; valid 1 cycle after tap_EN
//   ap_start_o     out  1   one-cycle start pulse to the engine
//   data_length_o  out  32  sample count latched at 0x10
//   eng_done_i     in   1   one-cycle pulse when the last output sample is consumed
// BEHAVIOUR
//   Reset values:
//     - awready, wready, arready, rvalid, tap_EN, tap_WE, ap_start_o = 0
//     - rdata, data_length_o, tap_A, tap_Di = 0
//     - ap_idle = 1, ap_done = 0
//   Register map:
//     - 0x00 ap_ctrl: [0] ap_start (write-1), [1] ap_done (read-to-clear), [2] ap_idle (read-only)
//     - 0x10 data_length
//     - TAP_BASE + 4*i for i < TAP_NUM: tap word i
//     - Any other address is unmapped.
//   Main FSM: IDLE, WR, AR, RD_WAIT, RD_RESP.
//     - IDLE, awvalid & wvalid -> WR. Write has priority over a simultaneous arvalid.
//     - WR: awready = wready = 1 for exactly 1 cycle. The write commits in that cycle. -> IDLE.
//     - IDLE, arvalid -> AR: arready = 1 for 1 cycle; address is captured.
//       Tap address: tap_EN = 1 this cycle, then -> RD_WAIT. Otherwise -> RD_RESP.
//     - RD_WAIT: capture tap_Do -> RD_RESP. Fixed tap read latency is 1 cycle.
//     - RD_RESP: rvalid = 1; rdata stays stable until rvalid & rready, then -> IDLE.
//     - Minimum latency: write ack 1 cycle after request; register read 2 cycles after arvalid; tap read 3 cycles.
//   ap_ctrl:
//     - Write with wdata[0] = 1 while ap_idle = 1:
//       ap_start_o pulses 1 cycle after the WR cycle; ap_idle <- 0 and ap_done <- 0 in that same cycle.
//     - Writes to 0x00 while busy (ap_idle = 0) are acked and ignored.
//     - eng_done_i: ap_done <- 1 and ap_idle <- 1 on the next edge. A pulse while idle is ignored.
//     - ap_done clears on the rvalid & rready handshake of a 0x00 read.
//       If eng_done_i arrives in that same cycle, the set wins; the read returns the old value.
//   Busy protection (ap_idle = 0):
//     - Writes to 0x10 and to taps are acked but dropped; tap_EN stays 0.
//     - Tap reads return 32'hFFFF_FFFF without enabling the SRAM.
//   Unmapped write: acked and dropped. Unmapped read: returns 0.
//   Tap writes: tap_EN = 1 and tap_WE = 4'hF in the WR cycle; tap_A and tap_Di are driven in that cycle.
//   Reset mid-transaction (async): the FSM returns to IDLE and all outputs return to reset values immediately.
//     The in-flight transaction is lost and the master re-issues it.
// STRUCTURE
//   Package fir_pkg holds:
//     - register offsets (ADDR_AP_CTRL, ADDR_DATA_LEN, TAP_BASE)
//     - ap_ctrl bit indices
//     - the FSM state enum
//   Single flat module; no sub-module. The tap SRAM is instantiated outside this block.
// TESTING
//   1. Reset, read 0x00 -> rdata = 32'h4 (idle), arready 1 cycle after arvalid, rvalid 1 cycle later.
//   2. Write taps 0..10 with values 1..11 and read each back -> matching values;
//      tap reads show rvalid 3 cycles after arvalid.
//   3. Write 0x10 = 64, then 0x00 = 1 -> ap_start_o 1-cycle pulse, ap_idle = 0, data_length_o = 64.
//      Then a tap read returns 32'hFFFF_FFFF and a write of 0x10 = 5 leaves data_length_o at 64.
//   4. Pulse eng_done_i -> read 0x00 returns 32'h6; the next read returns 32'h4.
//      Repeat with eng_done_i aligned to the read handshake -> 2nd read returns 32'h6.
//   5. Hold rready low 5 cycles during a read -> rvalid and rdata stable. Read 0x200 -> 0.
//      Write 0x200 -> acked, no side effect.
//   6. Assert axis_rst_n low in RD_RESP -> rvalid drops asynchronously; re-read after release succeeds.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR AXI-Lite control block: register offsets,
// ap_ctrl bit positions and the bus FSM state encoding.
package fir_pkg;

   localparam logic [11:0] ADDR_AP_CTRL  = 12'h000;
   localparam logic [11:0] ADDR_DATA_LEN = 12'h010;
   localparam logic [11:0] TAP_BASE      = 12'h080;

   localparam int AP_START_BIT = 0;
   localparam int AP_DONE_BIT  = 1;
   localparam int AP_IDLE_BIT  = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_AR,
      ST_RD_WAIT,
      ST_RD_RESP
   } state_t;

endpackage

// File: rtl/fir_axil_ctrl.sv
// AXI-Lite register slave for the FIR engine: ap_ctrl handshake, data_length
// and a pass-through window onto the external tap-coefficient SRAM.
module fir_axil_ctrl
   import fir_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 12,
   parameter int                    DATA_WIDTH = 32,
   parameter int                    TAP_NUM    = 11,
   parameter logic [ADDR_WIDTH-1:0] TAP_BASE   = fir_pkg::TAP_BASE
) (
   input  logic                    axis_clk,
   input  logic                    axis_rst_n,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    wvalid,
   output logic                    wready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic                    arvalid,
   output logic                    arready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   output logic                    rvalid,
   input  logic                    rready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic                    tap_EN,
   output logic [3:0]              tap_WE,
   output logic [ADDR_WIDTH-1:0]   tap_A,
   output logic [DATA_WIDTH-1:0]   tap_Di,
   input  logic [DATA_WIDTH-1:0]   tap_Do,
   output logic                    ap_start_o,
   output logic [DATA_WIDTH-1:0]   data_length_o,
   input  logic                    eng_done_i
);

   localparam logic [ADDR_WIDTH-1:0] A_CTRL = ADDR_WIDTH'(ADDR_AP_CTRL);
   localparam logic [ADDR_WIDTH-1:0] A_LEN  = ADDR_WIDTH'(ADDR_DATA_LEN);

   state_t                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   rd_addr_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [DATA_WIDTH-1:0]   data_len_q;
   logic                    ap_idle_q;
   logic                    ap_done_q;
   logic                    ap_start_q;

   logic                    aw_is_tap;
   logic                    ar_is_tap;
   logic                    wr_commit;
   logic                    rd_handshake;
   logic                    start_req;
   logic                    done_clear;

   // Word-aligned addresses inside the tap window; anything else is unmapped.
   function automatic logic is_tap(input logic [ADDR_WIDTH-1:0] addr);
      logic [ADDR_WIDTH-1:0] ofs;
      ofs = addr - TAP_BASE;
      return (addr >= TAP_BASE) && (ofs < ADDR_WIDTH'(4 * TAP_NUM)) &&
             (addr[1:0] == 2'b00);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] ctrl_word(input logic idle, input logic done);
      logic [DATA_WIDTH-1:0] w;
      w              = '0;
      w[AP_IDLE_BIT] = idle;
      w[AP_DONE_BIT] = done;
      return w;
   endfunction

   assign aw_is_tap    = is_tap(awaddr);
   assign ar_is_tap    = is_tap(araddr);
   assign wr_commit    = (state_q == ST_WR);
   assign rd_handshake = (state_q == ST_RD_RESP) && rready;
   assign start_req    = wr_commit && (awaddr == A_CTRL) && wdata[AP_START_BIT] && ap_idle_q;
   assign done_clear   = rd_handshake && (rd_addr_q == A_CTRL);

   // NOTE: async active-low reset in the sensitivity list; state uses
   // non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) state_q <= ST_IDLE;
      else             state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (awvalid && wvalid) state_d = ST_WR;
            else if (arvalid)      state_d = ST_AR;
         end
         ST_WR:      state_d = ST_IDLE;
         ST_AR:      state_d = (ar_is_tap && ap_idle_q) ? ST_RD_WAIT : ST_RD_RESP;
         ST_RD_WAIT: state_d = ST_RD_RESP;
         ST_RD_RESP: if (rready) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      awready = 1'b0;
      wready  = 1'b0;
      arready = 1'b0;
      rvalid  = 1'b0;
      tap_EN  = 1'b0;
      tap_WE  = 4'h0;
      tap_A   = '0;
      tap_Di  = '0;
      unique case (state_q)
         ST_WR: begin
            awready = 1'b1;
            wready  = 1'b1;
            if (aw_is_tap && ap_idle_q) begin
               tap_EN = 1'b1;
               tap_WE = 4'hF;
               tap_A  = awaddr - TAP_BASE;
               tap_Di = wdata;
            end
         end
         ST_AR: begin
            arready = 1'b1;
            if (ar_is_tap && ap_idle_q) begin
               tap_EN = 1'b1;
               tap_A  = araddr - TAP_BASE;
            end
         end
         ST_RD_RESP: rvalid = 1'b1;
         default: ;
      endcase
   end

   // A start and an engine completion cannot coincide: start needs idle,
   // completion is only honoured while busy.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         ap_idle_q  <= 1'b1;
         ap_done_q  <= 1'b0;
         ap_start_q <= 1'b0;
         data_len_q <= '0;
      end else begin
         ap_start_q <= start_req;
         if (start_req) begin
            ap_idle_q <= 1'b0;
            ap_done_q <= 1'b0;
         end else if (eng_done_i && !ap_idle_q) begin
            ap_idle_q <= 1'b1;
            ap_done_q <= 1'b1;
         end else if (done_clear) begin
            ap_done_q <= 1'b0;
         end
         if (wr_commit && (awaddr == A_LEN) && ap_idle_q) data_len_q <= wdata;
      end
   end

   // Read data is snapshotted at address accept, so rdata holds the pre-clear value.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         rd_addr_q <= '0;
         rdata_q   <= '0;
      end else begin
         if (state_q == ST_AR) begin
            rd_addr_q <= araddr;
            if (ar_is_tap) begin
               if (!ap_idle_q) rdata_q <= '1;
            end else if (araddr == A_CTRL) begin
               rdata_q <= ctrl_word(ap_idle_q, ap_done_q);
            end else if (araddr == A_LEN) begin
               rdata_q <= data_len_q;
            end else begin
               rdata_q <= '0;
            end
         end else if (state_q == ST_RD_WAIT) begin
            rdata_q <= tap_Do;
         end
      end
   end

   assign rdata         = rdata_q;
   assign data_length_o = data_len_q;
   assign ap_start_o    = ap_start_q;

endmodule

// File: tb/tb_fir_axil_ctrl.sv
// Self-checking bench for fir_axil_ctrl: an address-map model predicts every
// read, and a small SRAM model stands in for the external tap memory.
module tb_fir_axil_ctrl;

   logic        axis_clk = 1'b0;
   logic        axis_rst_n;
   logic        awvalid, awready, wvalid, wready;
   logic [11:0] awaddr;
   logic [31:0] wdata;
   logic        arvalid, arready, rvalid, rready;
   logic [11:0] araddr;
   logic [31:0] rdata;
   logic        tap_EN;
   logic [3:0]  tap_WE;
   logic [11:0] tap_A;
   logic [31:0] tap_Di;
   logic [31:0] tap_Do;
   logic        ap_start_o;
   logic [31:0] data_length_o;
   logic        eng_done_i;

   int errors = 0;
   int checks = 0;

   // behavioural model of the register map
   logic        m_idle, m_done;
   logic [31:0] m_len;
   logic [31:0] m_taps [0:10];
   int          m_starts = 0;

   int          start_cnt = 0;
   int          tap_en_cnt = 0;
   logic [31:0] sram [0:1023];

   fir_axil_ctrl dut (
      .axis_clk      (axis_clk),
      .axis_rst_n    (axis_rst_n),
      .awvalid       (awvalid),
      .awready       (awready),
      .awaddr        (awaddr),
      .wvalid        (wvalid),
      .wready        (wready),
      .wdata         (wdata),
      .arvalid       (arvalid),
      .arready       (arready),
      .araddr        (araddr),
      .rvalid        (rvalid),
      .rready        (rready),
      .rdata         (rdata),
      .tap_EN        (tap_EN),
      .tap_WE        (tap_WE),
      .tap_A         (tap_A),
      .tap_Di        (tap_Di),
      .tap_Do        (tap_Do),
      .ap_start_o    (ap_start_o),
      .data_length_o (data_length_o),
      .eng_done_i    (eng_done_i)
   );

   always #5 axis_clk = ~axis_clk;

   // external tap SRAM: read-first, data out one cycle after enable
   always @(posedge axis_clk) begin
      if (tap_EN) begin
         tap_Do <= sram[tap_A[11:2]];
         for (int b = 0; b < 4; b++)
            if (tap_WE[b]) sram[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
         tap_en_cnt <= tap_en_cnt + 1;
      end
      if (ap_start_o) start_cnt <= start_cnt + 1;
   end

   function automatic bit model_is_tap(input logic [11:0] a);
      return (a >= 12'h080) && (a < 12'h0AC) && (a[1:0] == 2'b00);
   endfunction

   function automatic logic [31:0] exp_read(input logic [11:0] a);
      if (a == 12'h000) return {29'd0, m_idle, m_done, 1'b0};
      if (a == 12'h010) return m_len;
      if (model_is_tap(a)) return m_idle ? m_taps[(a - 12'h080) >> 2] : 32'hFFFF_FFFF;
      return 32'h0;
   endfunction

   task automatic model_write(input logic [11:0] a, input logic [31:0] d);
      if (a == 12'h000) begin
         if (d[0] && m_idle) begin
            m_idle = 1'b0;
            m_done = 1'b0;
            m_starts++;
         end
      end else if (m_idle) begin
         if (a == 12'h010) m_len = d;
         else if (model_is_tap(a)) m_taps[(a - 12'h080) >> 2] = d;
      end
   endtask

   task automatic model_after_read(input logic [11:0] a, input bit done_pulse);
      if (done_pulse && !m_idle) begin
         m_idle = 1'b1;
         m_done = 1'b1;
      end else if (a == 12'h000) begin
         m_done = 1'b0;
      end
   endtask

   task automatic model_reset();
      m_idle = 1'b1;
      m_done = 1'b0;
      m_len  = 32'h0;
   endtask

   task automatic bus_idle();
      awvalid = 0; wvalid = 0; arvalid = 0; rready = 0; eng_done_i = 0;
      awaddr = '0; wdata = '0; araddr = '0;
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [31:0] d, output int lat);
      int n;
      @(negedge axis_clk);
      awaddr = a; wdata = d; awvalid = 1; wvalid = 1;
      n = 0;
      do begin
         @(negedge axis_clk);
         n++;
      end while (!(awready && wready) && n < 20);
      lat = (awready && wready) ? n : -1;
      if (lat < 0) begin
         checks++; errors++;
         $display("FAIL write_timeout: addr %h got no ready within %0d cycles", a, n);
      end
      @(negedge axis_clk);
      awvalid = 0; wvalid = 0;
      if (lat > 0) model_write(a, d);
   endtask

   task automatic bus_read(input logic [11:0] a, input bit done_at_hs,
                           output logic [31:0] d, output int ar_lat, output int rv_lat);
      int n;
      d = 'x; ar_lat = -1; rv_lat = -1;
      @(negedge axis_clk);
      araddr = a; arvalid = 1;
      n = 0;
      do begin
         @(negedge axis_clk);
         n++;
      end while (!arready && n < 20);
      if (!arready) begin
         checks++; errors++;
         $display("FAIL read_ar_timeout: addr %h got no arready within %0d cycles", a, n);
         arvalid = 0;
         return;
      end
      ar_lat = n;
      @(negedge axis_clk);
      arvalid = 0;
      n++;
      while (!rvalid && n < 20) begin
         @(negedge axis_clk);
         n++;
      end
      if (!rvalid) begin
         checks++; errors++;
         $display("FAIL read_r_timeout: addr %h got no rvalid within %0d cycles", a, n);
         return;
      end
      rv_lat = n;
      d = rdata;
      rready = 1;
      if (done_at_hs) eng_done_i = 1;
      @(negedge axis_clk);
      rready = 0;
      eng_done_i = 0;
      model_after_read(a, done_at_hs);
   endtask

   task automatic pulse_done();
      @(negedge axis_clk);
      eng_done_i = 1;
      @(negedge axis_clk);
      eng_done_i = 0;
      if (!m_idle) begin
         m_idle = 1'b1;
         m_done = 1'b1;
      end
   endtask

   task automatic test_reset();
      logic [31:0] d, e;
      int al, rl;
      bus_idle();
      model_reset();
      axis_rst_n = 0;
      #3;
      checks++;
      if ({awready, wready, arready, rvalid, tap_EN, tap_WE, ap_start_o} !== 10'h0 ||
          rdata !== 0 || data_length_o !== 0 || tap_A !== 0 || tap_Di !== 0) begin
         errors++;
         $display("FAIL reset_outputs: rvalid=%b rdata=%h len=%h tap_EN=%b, all required 0",
                  rvalid, rdata, data_length_o, tap_EN);
      end
      repeat (2) @(negedge axis_clk);
      axis_rst_n = 1;
      e = exp_read(12'h000);
      bus_read(12'h000, 0, d, al, rl);
      checks++;
      if (d !== 32'h4 || d !== e) begin
         errors++; $display("FAIL reset_ctrl_read: got %h want %h", d, e);
      end
      checks++;
      if (al !== 1 || rl !== 2) begin
         errors++; $display("FAIL reset_read_latency: arready %0d rvalid %0d, want 1 and 2", al, rl);
      end
   endtask

   task automatic test_taps();
      logic [31:0] d, e;
      int al, rl, wl;
      for (int i = 0; i < 11; i++) begin
         bus_write(12'h080 + 12'(4 * i), 32'(i + 1), wl);
         checks++;
         if (wl !== 1) begin
            errors++; $display("FAIL tap_write_latency[%0d]: got %0d want 1", i, wl);
         end
      end
      for (int i = 0; i < 11; i++) begin
         e = exp_read(12'h080 + 12'(4 * i));
         bus_read(12'h080 + 12'(4 * i), 0, d, al, rl);
         checks++;
         if (d !== e || d !== 32'(i + 1)) begin
            errors++; $display("FAIL tap_readback[%0d]: got %h want %h", i, d, e);
         end
         checks++;
         if (al !== 1 || rl !== 3) begin
            errors++; $display("FAIL tap_read_latency[%0d]: arready %0d rvalid %0d, want 1 and 3", i, al, rl);
         end
      end
   endtask

   task automatic test_start_busy();
      logic [31:0] d, e;
      int al, rl, wl, en0;
      bus_write(12'h010, 32'd64, wl);
      bus_write(12'h000, 32'h1, wl);
      checks++;
      if (ap_start_o !== 1'b1) begin
         errors++; $display("FAIL start_pulse_high: got %b want 1", ap_start_o);
      end
      @(negedge axis_clk);
      checks++;
      if (ap_start_o !== 1'b0) begin
         errors++; $display("FAIL start_pulse_width: got %b want 0", ap_start_o);
      end
      checks++;
      if (data_length_o !== 32'd64) begin
         errors++; $display("FAIL data_length: got %0d want 64", data_length_o);
      end
      e = exp_read(12'h000);
      bus_read(12'h000, 0, d, al, rl);
      checks++;
      if (d !== e || d[2] !== 1'b0) begin
         errors++; $display("FAIL busy_ctrl_read: got %h want %h", d, e);
      end
      en0 = tap_en_cnt;
      e = exp_read(12'h084);
      bus_read(12'h084, 0, d, al, rl);
      checks++;
      if (d !== e || d !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL busy_tap_read: got %h want %h", d, e);
      end
      bus_write(12'h010, 32'd5, wl);
      bus_write(12'h088, 32'hDEAD_BEEF, wl);
      checks++;
      if (data_length_o !== 32'd64) begin
         errors++; $display("FAIL busy_len_write: got %0d want 64", data_length_o);
      end
      checks++;
      if (tap_en_cnt !== en0) begin
         errors++; $display("FAIL busy_tap_enable: %0d enables while busy, want 0", tap_en_cnt - en0);
      end
   endtask

   task automatic test_done();
      logic [31:0] d, e;
      int al, rl, wl;
      pulse_done();
      e = exp_read(12'h000);
      bus_read(12'h000, 0, d, al, rl);
      checks++;
      if (d !== e || d !== 32'h6) begin
         errors++; $display("FAIL done_read1: got %h want %h", d, e);
      end
      e = exp_read(12'h000);
      bus_read(12'h000, 0, d, al, rl);
      checks++;
      if (d !== e || d !== 32'h4) begin
         errors++; $display("FAIL done_read2: got %h want %h", d, e);
      end
      // completion coinciding with the clearing handshake: set wins
      bus_write(12'h000, 32'h1, wl);
      e = exp_read(12'h000);
      bus_read(12'h000, 1, d, al, rl);
      checks++;
      if (d !== e || d !== 32'h0) begin
         errors++; $display("FAIL done_race_read1: got %h want %h", d, e);
      end
      e = exp_read(12'h000);
      bus_read(12'h000, 0, d, al, rl);
      checks++;
      if (d !== e || d !== 32'h6) begin
         errors++; $display("FAIL done_race_read2: got %h want %h", d, e);
      end
      pulse_done();
      e = exp_read(12'h000);
      bus_read(12'h000, 0, d, al, rl);
      checks++;
      if (d !== e || d !== 32'h4) begin
         errors++; $display("FAIL done_idle_pulse: got %h want %h", d, e);
      end
   endtask

   task automatic test_stall_unmapped();
      logic [31:0] d, e, held;
      int al, rl, wl, n, en0, st0;
      e = exp_read(12'h010);
      @(negedge axis_clk);
      araddr = 12'h010; arvalid = 1;
      @(negedge axis_clk);
      @(negedge axis_clk);
      arvalid = 0;
      n = 0;
      while (!rvalid && n < 20) begin
         @(negedge axis_clk);
         n++;
      end
      held = rdata;
      for (int i = 0; i < 5; i++) begin
         @(negedge axis_clk);
         checks++;
         if (rvalid !== 1'b1 || rdata !== e) begin
            errors++; $display("FAIL stall_hold[%0d]: rvalid %b rdata %h want 1 %h", i, rvalid, rdata, e);
         end
      end
      rready = 1;
      @(negedge axis_clk);
      rready = 0;
      checks++;
      if (rvalid !== 1'b0 || held !== e) begin
         errors++; $display("FAIL stall_release: rvalid %b data %h want 0 %h", rvalid, held, e);
      end
      bus_read(12'h200, 0, d, al, rl);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL unmapped_read: got %h want 0", d);
      end
      bus_read(12'h0AC, 0, d, al, rl);
      checks++;
      if (d !== 32'h0) begin
         errors++; $display("FAIL past_last_tap_read: got %h want 0", d);
      end
      en0 = tap_en_cnt;
      st0 = start_cnt;
      bus_write(12'h200, 32'hFFFF_FFFF, wl);
      bus_write(12'h0AC, 32'h1234_5678, wl);
      checks++;
      if (wl !== 1 || tap_en_cnt !== en0 || start_cnt !== st0 || data_length_o !== m_len) begin
         errors++; $display("FAIL unmapped_write: lat %0d tap_en %0d start %0d, want 1 0 0",
                            wl, tap_en_cnt - en0, start_cnt - st0);
      end
      e = exp_read(12'h0A8);
      bus_read(12'h0A8, 0, d, al, rl);
      checks++;
      if (d !== e) begin
         errors++; $display("FAIL last_tap_intact: got %h want %h", d, e);
      end
   endtask

   task automatic test_random();
      logic [31:0] d, e, wd;
      logic [11:0] a;
      int al, rl, wl, st0, op, k;
      logic [11:0] odd [0:4];
      odd[0] = 12'h200; odd[1] = 12'h004; odd[2] = 12'h082; odd[3] = 12'h0AC; odd[4] = 12'hFFC;
      st0 = start_cnt;
      m_starts = 0;
      for (int it = 0; it < 60; it++) begin
         k = $urandom_range(0, 5);
         case (k)
            0:       a = 12'h000;
            1:       a = 12'h010;
            2, 3:    a = 12'h080 + 12'(4 * $urandom_range(0, 10));
            4:       a = odd[$urandom_range(0, 4)];
            default: a = 12'h07C;
         endcase
         op = $urandom_range(0, 9);
         if (op < 4) begin
            wd = $urandom;
            bus_write(a, wd, wl);
            checks++;
            if (wl !== 1) begin
               errors++; $display("FAIL rand_write_latency[%0d]: got %0d want 1", it, wl);
            end
         end else if (op < 8) begin
            e = exp_read(a);
            bus_read(a, ($urandom_range(0, 3) == 0), d, al, rl);
            checks++;
            if (d !== e) begin
               errors++; $display("FAIL rand_read[%0d] addr %h: got %h want %h", it, a, d, e);
            end
         end else begin
            pulse_done();
         end
      end
      repeat (2) @(negedge axis_clk);
      checks++;
      if (start_cnt - st0 !== m_starts) begin
         errors++; $display("FAIL rand_start_count: got %0d want %0d", start_cnt - st0, m_starts);
      end
   endtask

   task automatic test_mid_reset();
      logic [31:0] d, e;
      int al, rl, n;
      @(negedge axis_clk);
      araddr = 12'h010; arvalid = 1;
      n = 0;
      do begin
         @(negedge axis_clk);
         n++;
         if (arready) arvalid = 0;
      end while (!rvalid && n < 20);
      arvalid = 0;
      checks++;
      if (rvalid !== 1'b1) begin
         errors++; $display("FAIL midreset_setup: rvalid %b want 1", rvalid);
      end
      #2 axis_rst_n = 0;
      #1;
      checks++;
      if (rvalid !== 1'b0 || arready !== 1'b0 || rdata !== 32'h0 || data_length_o !== 32'h0) begin
         errors++; $display("FAIL midreset_async: rvalid %b rdata %h len %h want 0 0 0",
                            rvalid, rdata, data_length_o);
      end
      model_reset();
      @(negedge axis_clk);
      axis_rst_n = 1;
      e = exp_read(12'h000);
      bus_read(12'h000, 0, d, al, rl);
      checks++;
      if (d !== e || d !== 32'h4 || rl !== 2) begin
         errors++; $display("FAIL midreset_reread: got %h lat %0d want %h lat 2", d, rl, e);
      end
      e = exp_read(12'h080);
      bus_read(12'h080, 0, d, al, rl);
      checks++;
      if (d !== e) begin
         errors++; $display("FAIL midreset_tap: got %h want %h", d, e);
      end
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
      for (int i = 0; i < 11; i++) m_taps[i] = 32'h0;
      tap_Do = 32'h0;
      test_reset();
      test_taps();
      test_start_busy();
      test_done();
      test_stall_unmapped();
      test_random();
      test_mid_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
